// File: rtl/game_screen_ctrl.sv
// game_screen_ctrl: screen sequencer for a two-player game.
// Walks START -> PLAY -> P1_WON/P2_WON -> START, switching screens only on
// frame boundaries so the visible region is never torn.
// Optional feature macro: GAME_SCREEN_BLINK_EN (blinking win banner).
// Without it the blink counter is not built and banner_on is tied high.
module game_screen_ctrl #(
  parameter int HOLD_FRAMES  = 120,
  parameter int BLINK_FRAMES = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vblnk,
  input  logic       start_btn,
  input  logic       p1_win,
  input  logic       p2_win,
  output logic [1:0] screen_sel,
  output logic       game_en,
  output logic       banner_on,
  output logic       frame_tick
);

  typedef enum logic [1:0] {
    S_START  = 2'b00,
    S_PLAY   = 2'b01,
    S_P1_WON = 2'b10,
    S_P2_WON = 2'b11
  } state_t;

  localparam int HOLD_W = (HOLD_FRAMES < 1) ? 1 : $clog2(HOLD_FRAMES + 1);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_FRAMES);

  // Parameter sanity: a blink half-period needs at least one frame.
  if (BLINK_FRAMES < 1 || HOLD_FRAMES < 0) begin : g_bad_param
    $error("game_screen_ctrl: BLINK_FRAMES must be >= 1 and HOLD_FRAMES >= 0");
  end

  state_t            state_reg;
  logic              vblnk_reg;
  logic              armed_reg;   // vblnk seen low since reset: next rise is a real edge
  logic              frame_tick_reg;
  logic              game_en_reg;
  logic              start_pend_reg;
  logic              p1_pend_reg;
  logic              p2_pend_reg;
  logic [HOLD_W-1:0] hold_cnt_reg;

  logic tick;
  logic in_won;
  logic start_ok;
  logic start_seen;
  logic p1_seen;
  logic p2_seen;

  // Boundary detect and the "seen since last boundary" views of the requests.
  always_comb begin
    tick       = vblnk & ~vblnk_reg & armed_reg;
    in_won     = state_reg[1];
    // Presses during the hold period are dropped, not queued.
    start_ok   = (state_reg == S_START) || (in_won && (hold_cnt_reg == '0));
    start_seen = start_pend_reg | (start_btn & start_ok);
    p1_seen    = p1_pend_reg | (p1_win & (state_reg == S_PLAY));
    p2_seen    = p2_pend_reg | (p2_win & (state_reg == S_PLAY));
  end

`ifdef GAME_SCREEN_BLINK_EN
  localparam int BLINK_W = $clog2(BLINK_FRAMES + 1);
  localparam logic [BLINK_W-1:0] BLINK_INIT = BLINK_W'(BLINK_FRAMES - 1);
  logic               banner_reg;
  logic [BLINK_W-1:0] blink_cnt_reg;
`endif

  // Screen FSM: all outputs registered and updated together on a boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= S_START;
      vblnk_reg      <= 1'b0;
      armed_reg      <= 1'b0;
      frame_tick_reg <= 1'b0;
      game_en_reg    <= 1'b0;
      start_pend_reg <= 1'b0;
      p1_pend_reg    <= 1'b0;
      p2_pend_reg    <= 1'b0;
      hold_cnt_reg   <= '0;
`ifdef GAME_SCREEN_BLINK_EN
      banner_reg     <= 1'b1;
      blink_cnt_reg  <= '0;
`endif
    end else begin
      vblnk_reg      <= vblnk;
      armed_reg      <= armed_reg | ~vblnk;
      frame_tick_reg <= tick;
      start_pend_reg <= start_seen;
      p1_pend_reg    <= p1_seen;
      p2_pend_reg    <= p2_seen;
      if (tick) begin
        case (state_reg)
          S_START: begin
            if (start_seen) begin
              state_reg      <= S_PLAY;
              game_en_reg    <= 1'b1;
              start_pend_reg <= 1'b0;
            end
          end
          S_PLAY: begin
            if (p1_seen || p2_seen) begin
              // Player 1 has fixed priority when both won in the same frame.
              state_reg      <= p1_seen ? S_P1_WON : S_P2_WON;
              game_en_reg    <= 1'b0;
              hold_cnt_reg   <= HOLD_INIT;
              start_pend_reg <= 1'b0;
              p1_pend_reg    <= 1'b0;
              p2_pend_reg    <= 1'b0;
`ifdef GAME_SCREEN_BLINK_EN
              banner_reg     <= 1'b1;
              blink_cnt_reg  <= BLINK_INIT;
`endif
            end
          end
          default: begin
            if (hold_cnt_reg == '0 && start_seen) begin
              state_reg      <= S_START;
              start_pend_reg <= 1'b0;
`ifdef GAME_SCREEN_BLINK_EN
              banner_reg     <= 1'b1;
              blink_cnt_reg  <= '0;
`endif
            end else begin
              if (hold_cnt_reg != '0) begin
                hold_cnt_reg <= hold_cnt_reg - HOLD_W'(1);
              end
`ifdef GAME_SCREEN_BLINK_EN
              if (blink_cnt_reg == '0) begin
                blink_cnt_reg <= BLINK_INIT;
                banner_reg    <= ~banner_reg;
              end else begin
                blink_cnt_reg <= blink_cnt_reg - BLINK_W'(1);
              end
`endif
            end
          end
        endcase
      end
    end
  end

  assign screen_sel = state_reg;
  assign game_en    = game_en_reg;
  assign frame_tick = frame_tick_reg;
`ifdef GAME_SCREEN_BLINK_EN
  assign banner_on  = banner_reg;
`else
  assign banner_on  = 1'b1;
`endif

endmodule

// File: tb/tb_game_screen_ctrl.sv
// tb_game_screen_ctrl: directed scenarios plus randomized frames, every
// cycle compared against a frame-level reference model of the screen flow.
module tb_game_screen_ctrl;

  localparam int HOLD  = 4;
  localparam int BLINK = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vblnk = 1'b0;
  logic       start_btn = 1'b0;
  logic       p1_win = 1'b0;
  logic       p2_win = 1'b0;
  logic [1:0] screen_sel;
  logic       game_en;
  logic       banner_on;
  logic       frame_tick;

  int checks = 0;
  int failures = 0;

  game_screen_ctrl #(.HOLD_FRAMES(HOLD), .BLINK_FRAMES(BLINK)) dut (
    .clk(clk), .rst(rst), .vblnk(vblnk), .start_btn(start_btn),
    .p1_win(p1_win), .p2_win(p2_win), .screen_sel(screen_sel),
    .game_en(game_en), .banner_on(banner_on), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // Reference model: screen number (0 start, 1 play, 2 p1 won, 3 p2 won),
  // frames shown in the current won screen, and requests seen this frame.
  int m_screen = 0;
  int m_won_frames = 0;
  bit m_start = 0, m_p1 = 0, m_p2 = 0;
  bit m_prev_v = 0, m_low_seen = 0, m_tick = 0;

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance the model by one clock with the inputs applied during that clock.
  task automatic model_step(input bit r, input bit v, input bit s, input bit w1, input bit w2);
    bit hold_over;
    if (r) begin
      m_screen = 0; m_won_frames = 0; m_start = 0; m_p1 = 0; m_p2 = 0;
      m_prev_v = 0; m_low_seen = 0; m_tick = 0;
      return;
    end
    // A boundary needs a low-to-high vblnk seen entirely after reset.
    m_tick = v && !m_prev_v && m_low_seen;
    if (!v) m_low_seen = 1;
    m_prev_v = v;
    hold_over = (m_screen >= 2) && (m_won_frames >= HOLD);
    if (s && (m_screen == 0 || hold_over)) m_start = 1;
    if (m_screen == 1) begin
      if (w1) m_p1 = 1;
      if (w2) m_p2 = 1;
    end
    if (m_tick) begin
      if (m_screen == 0 && m_start) begin
        m_screen = 1; m_start = 0;
      end else if (m_screen == 1 && (m_p1 || m_p2)) begin
        m_screen = m_p1 ? 2 : 3;
        m_won_frames = 0; m_p1 = 0; m_p2 = 0; m_start = 0;
      end else if (m_screen >= 2) begin
        if (hold_over && m_start) begin
          m_screen = 0; m_start = 0;
        end else begin
          m_won_frames++;
        end
      end
    end
  endtask

  function automatic int exp_banner();
`ifdef GAME_SCREEN_BLINK_EN
    if (m_screen >= 2) return ((m_won_frames / BLINK) % 2 == 0) ? 1 : 0;
`endif
    return 1;
  endfunction

  // One clock: drive inputs, step model at the edge, compare 1 ns later.
  task automatic cycle(input bit r, input bit v, input bit s, input bit w1, input bit w2);
    rst = r; vblnk = v; start_btn = s; p1_win = w1; p2_win = w2;
    @(posedge clk);
    model_step(r, v, s, w1, w2);
    #1;
    check_val("screen_sel", int'(screen_sel), m_screen);
    check_val("game_en", int'(game_en), (m_screen == 1) ? 1 : 0);
    check_val("banner_on", int'(banner_on), exp_banner());
    check_val("frame_tick", int'(frame_tick), int'(m_tick));
  endtask

  // One frame: lo cycles of active video then hi cycles of blanking.
  // s_at/p1_at/p2_at pick the active-video cycle of a one-cycle pulse (-1 = none).
  task automatic frame(input int lo, input int hi, input int s_at, input int p1_at, input int p2_at);
    for (int i = 0; i < lo; i++) cycle(0, 0, i == s_at, i == p1_at, i == p2_at);
    for (int i = 0; i < hi; i++) cycle(0, 1, 0, 0, 0);
  endtask

  initial begin
    // Reset while vblnk is high; releasing reset must not create a boundary.
    for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0, 0);
    check_val("rst_screen", int'(screen_sel), 0);
    check_val("rst_banner", int'(banner_on), 1);
    cycle(0, 1, 1, 0, 0);
    cycle(0, 1, 1, 0, 0);
    check_val("no_tick_after_rst", int'(frame_tick), 0);

    // Start press then boundary -> play.
    frame(4, 2, 1, -1, -1);
    check_val("start_to_play", int'(screen_sel), 1);
    check_val("play_game_en", int'(game_en), 1);

    // p2 wins mid-frame: stays in play until the boundary, then p2 screen.
    cycle(0, 0, 0, 0, 1);
    check_val("p2_waits_boundary", int'(screen_sel), 1);
    frame(3, 2, -1, -1, -1);
    check_val("p2_won", int'(screen_sel), 3);
    check_val("p2_game_en_off", int'(game_en), 0);

    // Back to play via a fresh reset; both win in one frame -> p1 priority.
    cycle(1, 0, 0, 0, 0);
    frame(3, 2, 0, -1, -1);
    frame(5, 2, -1, 2, 2);
    check_val("both_win_p1", int'(screen_sel), 2);

    // Hold: press after second won frame is dropped, press after fourth is taken.
    frame(3, 2, -1, -1, -1);
    frame(3, 2, -1, -1, -1);
    frame(3, 2, 1, -1, -1);
    check_val("hold_press_dropped", int'(screen_sel), 2);
    frame(3, 2, -1, -1, -1);
    frame(3, 2, 1, -1, -1);
    check_val("hold_done_restart", int'(screen_sel), 0);

    // Reset while in p2 screen with three hold frames remaining.
    frame(3, 2, 0, -1, -1);
    frame(3, 2, -1, -1, 1);
    frame(3, 1, -1, -1, -1);
    check_val("pre_rst_p2", int'(screen_sel), 3);
    cycle(1, 1, 0, 0, 0);
    check_val("rst_mid_hold_sel", int'(screen_sel), 0);
    check_val("rst_mid_hold_banner", int'(banner_on), 1);
    for (int i = 0; i < 3; i++) cycle(0, 1, 1, 0, 0);
    check_val("rst_hold_no_move", int'(screen_sel), 0);

    // Randomized frames with occasional resets.
    for (int f = 0; f < 120; f++) begin
      int lo, hi, s_at, p1_at, p2_at;
      lo = $urandom_range(2, 6);
      hi = $urandom_range(1, 3);
      s_at  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, lo - 1) : -1;
      p1_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, lo - 1) : -1;
      p2_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, lo - 1) : -1;
      if ($urandom_range(0, 39) == 0) cycle(1, $urandom_range(0, 1), 0, 0, 0);
      frame(lo, hi, s_at, p1_at, p2_at);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
